mpm_port_dispatcher: RTL

//   Front end of the multi-ported LVT memory. Takes one valid/ready request stream per port and buffers it in a 2-entry FIFO per port.

---
 rtl/mpm_port_dispatcher_if.sv | 31 +++
 rtl/mpm_port_dispatcher.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mpm_port_dispatcher_if.sv
// Request, memory-array and response bundle shared by the ports, dispatcher and LVT memory.
// slave = dispatcher side; master = requesters plus memory (the bench plays both).
interface mpm_port_dispatcher_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PORTS = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_ready;
  logic [PORTS-1:0]            req_write;
  logic [PORTS-1:0][AW-1:0]    req_addr;
  logic [PORTS-1:0][WIDTH-1:0] req_data;
  logic [PORTS-1:0][AW-1:0]    mem_addr;
  logic [PORTS-1:0]            mem_en;
  logic [PORTS-1:0][WIDTH-1:0] mem_d;
  logic [PORTS-1:0][WIDTH-1:0] mem_q;
  logic [PORTS-1:0]            rsp_valid;
  logic [PORTS-1:0][WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, mem_q,
    input  req_ready, mem_addr, mem_en, mem_d, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, mem_q,
    output req_ready, mem_addr, mem_en, mem_d, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mpm_port_dispatcher.sv
// Per-port 2-entry request FIFOs feeding registered LVT memory ports, with lowest-index-wins
// same-address write arbitration. Optional counters under MPM_DISPATCH_STATS_EN.
module mpm_port_dispatcher #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned PORTS       = 4,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mpm_port_dispatcher_if.slave bus
`ifdef MPM_DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_stalls,
  output logic [31:0]          stat_reads
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic             write;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } req_t;

  req_t [PORTS-1:0][1:0]             fifo_q;
  logic [PORTS-1:0][1:0]             cnt_q;
  logic [PORTS-1:0]                  wptr_q, rptr_q;
  logic [PORTS-1:0][AW-1:0]          mem_addr_q;
  logic [PORTS-1:0][WIDTH-1:0]       mem_d_q;
  logic [PORTS-1:0]                  mem_en_q;
  logic [PORTS-1:0]                  rd_q;
  logic [PORTS-1:0][MEM_LATENCY-1:0] rd_sr_q;

  req_t [PORTS-1:0] head;
  logic [PORTS-1:0] head_vld, push, stall, issue, issue_rd;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      head[p]          = fifo_q[p][rptr_q[p]];
      head_vld[p]      = (cnt_q[p] != 2'd0);
      bus.req_ready[p] = !rst && (cnt_q[p] != 2'd2);
      push[p]          = bus.req_valid[p] && bus.req_ready[p];
    end
    for (int p = 0; p < PORTS; p++) begin
      stall[p] = 1'b0;
      // Any lower valid write head to the same address means this write loses; the winner
      // of that group is always the lowest index, so its own issue need not be re-derived.
      for (int q = 0; q < p; q++) begin
        if (head_vld[q] && head[q].write && head[q].addr == head[p].addr) stall[p] = 1'b1;
      end
      stall[p]    = stall[p] && head_vld[p] && head[p].write;
      issue[p]    = head_vld[p] && !stall[p];
      issue_rd[p] = issue[p] && !head[p].write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      mem_en_q   <= '0;
      rd_q       <= '0;
      rd_sr_q    <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (push[p]) begin
          fifo_q[p][wptr_q[p]] <= req_t'{write: bus.req_write[p], addr: bus.req_addr[p],
                                         data: bus.req_data[p]};
          wptr_q[p] <= ~wptr_q[p];
        end
        if (issue[p]) begin
          rptr_q[p]     <= ~rptr_q[p];
          mem_addr_q[p] <= head[p].addr;
          mem_d_q[p]    <= head[p].data;
        end
        cnt_q[p]      <= cnt_q[p] + {1'b0, push[p]} - {1'b0, issue[p]};
        mem_en_q[p]   <= issue[p] && head[p].write;
        rd_q[p]       <= issue_rd[p];
        rd_sr_q[p][0] <= rd_q[p];
        for (int i = 1; i < MEM_LATENCY; i++) rd_sr_q[p][i] <= rd_sr_q[p][i-1];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) bus.rsp_valid[p] = rd_sr_q[p][MEM_LATENCY-1];
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.rsp_data = bus.mem_q;

`ifdef MPM_DISPATCH_STATS_EN
  logic [31:0] stalls_q, reads_q, n_stall, n_read;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    n_stall = '0;
    n_read  = '0;
    for (int p = 0; p < PORTS; p++) begin
      n_stall = n_stall + 32'(stall[p]);
      n_read  = n_read + 32'(issue_rd[p]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalls_q <= '0;
      reads_q  <= '0;
    end else begin
      stalls_q <= sat_add(stalls_q, n_stall);
      reads_q  <= sat_add(reads_q, n_read);
    end
  end

  assign stat_stalls = stalls_q;
  assign stat_reads  = reads_q;
`endif
endmodule
